// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared state type and framing constants for the UART transmitter
package uart_pkg;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;

  localparam int DATA_BITS = 8;
  localparam int STOP_BITS = 1;
endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - show-ahead synchronous FIFO with registered full/empty flags
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [PW-1:0]    wr_ptr_n, rd_ptr_n;
  logic             do_wr, do_rd;

  assign do_wr    = wr_en && !full;
  assign do_rd    = rd_en && !empty;
  assign wr_ptr_n = wr_ptr + PW'(do_wr);
  assign rd_ptr_n = rd_ptr + PW'(do_rd);

  // Flags come from the next pointers so they are registered yet exact one cycle later.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      wr_ptr <= wr_ptr_n;
      rd_ptr <= rd_ptr_n;
      full   <= (wr_ptr_n ^ rd_ptr_n) == {1'b1, {AW{1'b0}}};
      empty  <= (wr_ptr_n == rd_ptr_n);
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

  assign rd_data = mem[rd_ptr[AW-1:0]];
endmodule

// File: rtl/uart_ascii_tx.sv
// rtl/uart_ascii_tx.sv - FIFO-buffered 8N1 UART transmitter for latched ASCII bytes
module uart_ascii_tx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD       = 9600,
  parameter int FIFO_DEPTH = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  output logic       full,
  output logic       empty,
  output logic       busy,
  output logic       tx
);
  localparam int DIV   = CLK_FREQ / BAUD;
  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int BIT_W = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

  tx_state_t            state, state_n;
  logic [CNT_W-1:0]     cnt, cnt_n;
  logic [BIT_W-1:0]     bit_idx, bit_n;
  logic [DATA_BITS-1:0] shreg, shreg_n;
  logic [DATA_BITS-1:0] head;
  logic                 tx_n, rd_en, baud_tick;

  sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .rd_en   (rd_en),
    .rd_data (head),
    .full    (full),
    .empty   (empty)
  );

  assign baud_tick = (cnt == CNT_LAST);
  assign busy      = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      tx      <= 1'b1;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      bit_idx <= bit_n;
      shreg   <= shreg_n;
      tx      <= tx_n;
    end
  end

  // tx_n is the line level for the cycle after this edge, so tx stays a clean register.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    bit_n   = bit_idx;
    shreg_n = shreg;
    tx_n    = tx;
    rd_en   = 1'b0;
    if (state != IDLE) cnt_n = baud_tick ? '0 : cnt + 1'b1;
    case (state)
      IDLE: begin
        tx_n = 1'b1;
        if (!empty) begin
          rd_en   = 1'b1;
          shreg_n = head;
          cnt_n   = '0;
          bit_n   = '0;
          tx_n    = 1'b0;
          state_n = START;
        end
      end
      START: begin
        if (baud_tick) begin
          tx_n    = shreg[0];
          state_n = DATA;
        end
      end
      DATA: begin
        if (baud_tick) begin
          if (bit_idx == BIT_W'(DATA_BITS - 1)) begin
            bit_n   = '0;
            tx_n    = 1'b1;
            state_n = STOP;
          end else begin
            shreg_n = shreg >> 1;
            tx_n    = shreg[1];
            bit_n   = bit_idx + 1'b1;
          end
        end
      end
      STOP: begin
        if (baud_tick) begin
          if (bit_idx == BIT_W'(STOP_BITS - 1)) state_n = IDLE;
          else bit_n = bit_idx + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end
endmodule

// File: tb/tb_uart_ascii_tx.sv
// tb/tb_uart_ascii_tx.sv - self-checking bench for uart_ascii_tx at DIV=16
module tb_uart_ascii_tx;
  localparam int DIV   = 16;
  localparam int DEPTH = 16;
  localparam int FRAME = 10 * DIV;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       full, empty, busy, tx;

  uart_ascii_tx #(.CLK_FREQ(160), .BAUD(10), .FIFO_DEPTH(DEPTH)) dut (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .full    (full),
    .empty   (empty),
    .busy    (busy),
    .tx      (tx)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference: a byte queue plus a position inside the current frame.
  logic [7:0] mq[$];
  logic [7:0] cur = 8'h00;
  logic       in_frame = 1'b0;
  int         pos = 0;

  logic txlog[$];
  logic busylog[$];

  typedef struct {
    logic [7:0] data;
    logic [9:0] frame;
  } vec_t;
  vec_t tbl[5];
  logic [7:0] burst_bytes[3];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic model_tx();
    int b;
    if (!in_frame) return 1'b1;
    b = pos / DIV;
    if (b == 0) return 1'b0;
    if (b == 9) return 1'b1;
    return cur[b-1];
  endfunction

  task automatic step(input logic w, input logic [7:0] d, input logic r);
    logic acc, pop;
    wr_en = w;
    wr_data = d;
    reset = r;
    @(posedge clk);
    if (r) begin
      mq.delete();
      in_frame = 1'b0;
      pos = 0;
    end else begin
      acc = w && (mq.size() < DEPTH);
      pop = !in_frame && (mq.size() > 0);
      if (pop) begin
        cur = mq.pop_front();
        in_frame = 1'b1;
        pos = 0;
      end else if (in_frame) begin
        pos++;
        if (pos == FRAME) in_frame = 1'b0;
      end
      if (acc) mq.push_back(d);
    end
    #1;
    txlog.push_back(tx);
    busylog.push_back(busy);
    check($sformatf("model edge %0d {tx,busy,empty,full}", txlog.size() - 1),
          {tx, busy, empty, full},
          {model_tx(), in_frame, mq.size() == 0, mq.size() == DEPTH});
    wr_en = 1'b0;
    reset = 1'b0;
  endtask

  function automatic logic [9:0] decode(input int s);
    logic [9:0] f;
    for (int k = 0; k < 10; k++) f[k] = txlog[s + DIV * k + DIV / 2];
    return f;
  endfunction

  function automatic int count_active(input int from);
    int c = 0;
    for (int i = from; i < txlog.size(); i++) if (txlog[i] !== 1'b1 || busylog[i] !== 1'b0) c++;
    return c;
  endfunction

  initial begin
    int w0;
    tbl[0] = '{8'h41, 10'b1_01000001_0};
    tbl[1] = '{8'h00, 10'b1_00000000_0};
    tbl[2] = '{8'hFF, 10'b1_11111111_0};
    tbl[3] = '{8'hA5, 10'b1_10100101_0};
    tbl[4] = '{8'h0D, 10'b1_00001101_0};
    burst_bytes[0] = 8'h55;
    burst_bytes[1] = 8'hAA;
    burst_bytes[2] = 8'h0D;

    step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b1);
    check("reset {tx,busy,empty,full}", {tx, busy, empty, full}, 4'b1010);

    // Single-byte frames with hand-written line patterns
    for (int i = 0; i < 5; i++) begin
      w0 = txlog.size();
      step(1'b1, tbl[i].data, 1'b0);
      repeat (FRAME + 10) step(1'b0, 8'h00, 1'b0);
      check("latency tx at write edge", txlog[w0], 1'b1);
      check("latency start bit", txlog[w0+1], 1'b0);
      check($sformatf("frame %0h", tbl[i].data), decode(w0 + 1), tbl[i].frame);
      check("busy at last stop cycle", busylog[w0+FRAME], 1'b1);
      check("busy falls", busylog[w0+FRAME+1], 1'b0);
    end

    // Burst of three: one idle cycle between frames
    w0 = txlog.size();
    for (int i = 0; i < 3; i++) step(1'b1, burst_bytes[i], 1'b0);
    repeat (3 * (FRAME + 1) + 20) step(1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 3; i++)
      check("burst frame", decode(w0 + 1 + (FRAME + 1) * i), {1'b1, burst_bytes[i], 1'b0});
    check("burst gap idle", busylog[w0+FRAME+1], 1'b0);
    check("burst gap restart", busylog[w0+FRAME+2], 1'b1);

    // Overflow, then a refused write on the pop edge while full
    step(1'b0, 8'h00, 1'b1);
    w0 = txlog.size();
    for (int n = 0; n < 2900; n++) begin
      step((n < 20) || (n == 162), (n == 162) ? 8'h77 : 8'(n), 1'b0);
      if (n == 16) check("overflow full set", full, 1'b1);
      if (n == 161) check("simul full before pop", full, 1'b1);
      if (n == 162) check("simul full after pop", full, 1'b0);
    end
    for (int i = 0; i < 17; i++)
      check($sformatf("overflow frame %0d", i), decode(w0 + 1 + (FRAME + 1) * i), {1'b1, 8'(i), 1'b0});
    check("overflow no extra frame", count_active(w0 + 1 + (FRAME + 1) * 17), 0);

    // Reset during DATA bit 3 of 0xFF with two bytes queued
    step(1'b0, 8'h00, 1'b1);
    w0 = txlog.size();
    step(1'b1, 8'hFF, 1'b0);
    step(1'b1, 8'h12, 1'b0);
    step(1'b1, 8'h34, 1'b0);
    repeat (67) step(1'b0, 8'h00, 1'b0);
    check("pre-reset busy", busy, 1'b1);
    step(1'b0, 8'h00, 1'b1);
    check("mid-frame reset {tx,busy,empty}", {tx, busy, empty}, 3'b101);
    repeat (400) step(1'b0, 8'h00, 1'b0);
    check("no frames after reset", count_active(w0 + 70), 0);

    // Idle line
    w0 = txlog.size();
    repeat (1000) step(1'b0, 8'h00, 1'b0);
    check("idle line quiet", count_active(w0), 0);

    // Random traffic against the reference
    for (int n = 0; n < 4000; n++)
      step($urandom_range(0, 99) < 4, 8'($urandom), $urandom_range(0, 2999) == 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
